bsw_tile_dispatcher: RTL and testbench
======================================

// Module: bsw_tile_dispatcher
// PURPOSE
// Schedules alignment tiles onto NUM_ARRAY banded-SW array instances and collects their 512-bit tile results.
// Accepts tile descriptors aimed at a host-chosen array, whose ref/query BRAMs the host has already loaded.
// Pulses that array's start, holds its per-tile fields until the result is drained, and broadcasts scoring parameters.
// Merges finished results through a round-robin arbiter into one valid/ready result stream, then issues clear_done.
// PARAMETERS
// NUM_ARRAY          4    number of array instances served
// PE_WIDTH           25   score width; parameter bus is 13*PE_WIDTH
// LOG_MAX_TILE_SIZE  11   width of length fields
// PORTS
// clk              in   1                      clock
// rst_n            in   1                      asynchronous active-low reset
// param_load       in   1                      pulse: latch param_in and broadcast it
// param_in         in   13*PE_WIDTH            scoring parameters
// param_ready      out  1                      1 = all slots IDLE; param_load is honoured
// desc_valid       in   1                      tile descriptor valid
// desc_ready       out  1                      descriptor accepted when valid&ready
// desc_array       in   $clog2(NUM_ARRAY)      target array index
// desc_tile_id     in   32                     tile id
// desc_ref_len     in   LOG_MAX_TILE_SIZE      ref length
// desc_query_len   in   LOG_MAX_TILE_SIZE      query length
// desc_align       in   8                      align_fields (reverse/complement bits)
// arr_set_param    out  NUM_ARRAY              per-array set_param
// arr_in_params    out  13*PE_WIDTH            registered parameter bus, shared
// arr_start        out  NUM_ARRAY              per-array start
// arr_ready        in   NUM_ARRAY              per-array ready
// arr_done         in   NUM_ARRAY              per-array done
// arr_clear_done   out  NUM_ARRAY              per-array clear_done
// arr_tile_id      out  NUM_ARRAY*32           per-array held tile id
// arr_ref_len      out  NUM_ARRAY*LOG_MAX_TILE_SIZE  per-array held ref length
// arr_query_len    out  NUM_ARRAY*LOG_MAX_TILE_SIZE  per-array held query length
// arr_align        out  NUM_ARRAY*8            per-array held align_fields
// arr_tile_output  in   NUM_ARRAY*512          per-array result word
// res_valid        out  1                      result word valid
// res_ready        in   1                      downstream accepts result
// res_data         out  512                    captured tile_output
// busy_mask        out  NUM_ARRAY              1 = slot not IDLE
// BEHAVIOUR
// - Reset: every output is 0 (including all registered buses); params_set=0; rr pointer=0; all slots IDLE.
// - Reset mid-tile: slots are abandoned; the array instances are reset by the system at the same time.
// - Per-slot FSM: IDLE -> START -> RUN -> WAIT -> CLEAR -> IDLE.
//   - IDLE->START: on descriptor accept.
//   - START: 1 cycle; arr_start[k]=1.
//   - RUN: until arr_done[k]=1.
//   - WAIT: arr_done high; after >=1 full cycle in WAIT the slot requests the arbiter (array's tile_output registers lag done by one cycle).
//   - CLEAR: entered when the slot's result is captured; 1 cycle; arr_clear_done[k]=1.
// - desc_ready = params_set & slot[desc_array]==IDLE & arr_ready[desc_array]; combinational on desc_array.
//   Accept latches the fields into that slot's arr_* held registers on the same edge; they stay stable until that slot returns to IDLE.
//   The array drives ref_len/query_len live into its tile_output, so the held values must stay stable until then.
// - Accept->arr_start latency: 1 cycle (start asserted in the cycle after the accept edge).
// - Params: param_load with param_ready=1 registers arr_in_params.
//   Next cycle, arr_set_param = all ones for exactly 1 cycle; params_set=1 from that edge.
//   param_load with param_ready=0 is ignored. Reloading while idle is allowed.
// - Result path: single output register.
//   Arbiter grants only when res_valid=0 or (res_valid & res_ready).
//   Grant copies arr_tile_output[k] to res_data, sets res_valid, moves slot k to CLEAR.
//   res_data is held while res_valid & ~res_ready. Back-to-back results are possible at 1 per cycle.
// - Round-robin: search starts at rr_ptr; after a grant to k, rr_ptr = (k+1) mod NUM_ARRAY. Slots are starvation-free.
// - Simultaneous events allowed: a descriptor accept on slot a and a grant on slot b!=a in the same cycle.
//   A slot in CLEAR cannot accept (not IDLE); the earliest re-accept is the cycle after CLEAR.
// - Widths: desc_array >= NUM_ARRAY is never accepted (desc_ready=0).
// STRUCTURE
// - bsw_sched_pkg: slot-state localparams (IDLE..CLEAR), RESULT_W=512, PARAM_W(PE_WIDTH) function.
// - Sub-module bsw_rr_arbiter #(N): req[N], advance, grant one-hot, rr pointer.
// - Top: NUM_ARRAY slot FSMs via generate, held-field registers, parameter broadcaster, result register.
// TESTING
// 1 Reset: rst_n low mid-RUN -> all outputs 0 immediately; desc_ready=0 until param_load.
// 2 param_load with 13 words 0x1..0xD -> arr_set_param=4'hF for 1 cycle; then desc_ready=1; param_load while busy -> ignored.
// 3 Descriptor arr=2, id=7, ref=100, query=90 -> arr_start=4'b0100 one cycle later.
//   Model arr_done: capture waits 1 cycle, then res_data equals model word; arr_clear_done[2] pulses once.
// 4 arr_done on slots 0,1,3 in the same cycle, rr_ptr=1 -> results emitted in order 1,3,0, one per cycle with res_ready=1.
// 5 Backpressure: res_ready=0 for 10 cycles -> res_data stable; no clear_done; other slots wait; all results emitted once released.
// 6 Descriptor to a busy slot -> desc_ready=0; descriptor to another slot accepted in the same cycle as a grant.

Source files
------------

// File: rtl/bsw_tile_dispatcher_pkg.sv
// Shared types and constants for the banded-SW tile dispatcher.
//   slot_state_e : per-array slot life cycle
//   RESULT_W     : width of one tile result word
//   param_w()    : width of the scoring-parameter bus for a given score width
package bsw_tile_dispatcher_pkg;

    localparam int RESULT_W  = 512;
    localparam int TILE_ID_W = 32;
    localparam int ALIGN_W   = 8;

    typedef enum logic [2:0] {
        SLOT_IDLE  = 3'd0,
        SLOT_START = 3'd1,
        SLOT_RUN   = 3'd2,
        SLOT_WAIT  = 3'd3,
        SLOT_CLEAR = 3'd4
    } slot_state_e;

    // Thirteen scoring words of pe_width bits each.
    function automatic int param_w(input int pe_width);
        return 13 * pe_width;
    endfunction

endpackage

// File: rtl/bsw_tile_dispatcher_if.sv
// Host-side streams of the tile dispatcher.
//   desc_* : tile descriptor stream (valid/ready) aimed at one array
//   res_*  : merged 512-bit result stream (valid/ready)
// master = host / testbench side, slave = dispatcher side.
interface bsw_tile_dispatcher_if #(
    parameter int NUM_ARRAY         = 4,
    parameter int LOG_MAX_TILE_SIZE = 11
);
    import bsw_tile_dispatcher_pkg::*;

    localparam int AW = (NUM_ARRAY > 1) ? $clog2(NUM_ARRAY) : 1;

    logic                         desc_valid;
    logic                         desc_ready;
    logic [AW-1:0]                desc_array;
    logic [TILE_ID_W-1:0]         desc_tile_id;
    logic [LOG_MAX_TILE_SIZE-1:0] desc_ref_len;
    logic [LOG_MAX_TILE_SIZE-1:0] desc_query_len;
    logic [ALIGN_W-1:0]           desc_align;

    logic                         res_valid;
    logic                         res_ready;
    logic [RESULT_W-1:0]          res_data;

    modport master (
        output desc_valid, desc_array, desc_tile_id, desc_ref_len, desc_query_len, desc_align,
        input  desc_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  desc_valid, desc_array, desc_tile_id, desc_ref_len, desc_query_len, desc_align,
        output desc_ready,
        output res_valid, res_data,
        input  res_ready
    );

endinterface

// File: rtl/bsw_tile_dispatcher_rr_arbiter.sv
// Round-robin arbiter for result collection.
//   req     : per-slot request
//   advance : output register can take a word this cycle
//   grant   : one-hot, only asserted while advance is high
// The search starts at the internal pointer; after a grant to k the pointer
// moves to k+1, so every requester is reached within N grants.
module bsw_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && advance && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bsw_tile_dispatcher.sv
// Schedules alignment tiles onto NUM_ARRAY banded-SW arrays and merges
// their 512-bit results into one valid/ready stream.
// Ports:
//   param_load/param_in/param_ready : scoring-parameter load, broadcast to all arrays
//   bus (slave)                      : descriptor in, result out
//   arr_*                            : per-array start/done/clear and held tile fields
//   busy_mask                        : 1 = slot not IDLE
//
// Slot states:
//   state      | meaning
//   SLOT_IDLE  | free, may accept a descriptor
//   SLOT_START | one-cycle arr_start pulse
//   SLOT_RUN   | array computing, waiting for arr_done
//   SLOT_WAIT  | done seen; requests the arbiter after one settle cycle
//   SLOT_CLEAR | result captured; one-cycle arr_clear_done pulse
module bsw_tile_dispatcher
    import bsw_tile_dispatcher_pkg::*;
#(
    parameter int NUM_ARRAY         = 4,
    parameter int PE_WIDTH          = 25,
    parameter int LOG_MAX_TILE_SIZE = 11,
    localparam int PW = param_w(PE_WIDTH),
    localparam int AW = (NUM_ARRAY > 1) ? $clog2(NUM_ARRAY) : 1,
    localparam int LW = LOG_MAX_TILE_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          param_load,
    input  logic [PW-1:0]                 param_in,
    output logic                          param_ready,
    bsw_tile_dispatcher_if.slave          bus,
    output logic [NUM_ARRAY-1:0]          arr_set_param,
    output logic [PW-1:0]                 arr_in_params,
    output logic [NUM_ARRAY-1:0]          arr_start,
    input  logic [NUM_ARRAY-1:0]          arr_ready,
    input  logic [NUM_ARRAY-1:0]          arr_done,
    output logic [NUM_ARRAY-1:0]          arr_clear_done,
    output logic [NUM_ARRAY*TILE_ID_W-1:0] arr_tile_id,
    output logic [NUM_ARRAY*LW-1:0]       arr_ref_len,
    output logic [NUM_ARRAY*LW-1:0]       arr_query_len,
    output logic [NUM_ARRAY*ALIGN_W-1:0]  arr_align,
    input  logic [NUM_ARRAY*RESULT_W-1:0] arr_tile_output,
    output logic [NUM_ARRAY-1:0]          busy_mask
);

    slot_state_e state_q [NUM_ARRAY];
    slot_state_e state_d [NUM_ARRAY];
    logic [NUM_ARRAY-1:0] waited_q, waited_d;
    logic [NUM_ARRAY-1:0] start_q, start_d;
    logic [NUM_ARRAY-1:0] clear_q, clear_d;
    logic [NUM_ARRAY-1:0] busy_q, busy_d;

    logic [NUM_ARRAY*TILE_ID_W-1:0] tile_id_q, tile_id_d;
    logic [NUM_ARRAY*LW-1:0]        ref_len_q, ref_len_d;
    logic [NUM_ARRAY*LW-1:0]        query_len_q, query_len_d;
    logic [NUM_ARRAY*ALIGN_W-1:0]   align_q, align_d;

    logic                 params_set_q, params_set_d;
    logic                 param_ready_q, param_ready_d;
    logic [NUM_ARRAY-1:0] set_param_q, set_param_d;
    logic [PW-1:0]        in_params_q, in_params_d;
    logic                 load_ok;

    logic                 res_valid_q, res_valid_d;
    logic [RESULT_W-1:0]  res_data_q, res_data_d;

    logic [NUM_ARRAY-1:0] accept, req, grant;
    logic                 can_grant;
    logic                 sel_ok;
    logic                 desc_ready;

    assign load_ok = param_load & param_ready_q;

    // A parameter load wins over a same-cycle descriptor so no array ever
    // sees set_param after it has been started.
    always_comb begin
        sel_ok = 1'b0;
        accept = '0;
        for (int k = 0; k < NUM_ARRAY; k++) begin
            if (bus.desc_array == AW'(k))
                sel_ok = (state_q[k] == SLOT_IDLE) && arr_ready[k];
        end
        desc_ready = params_set_q && sel_ok && !load_ok;
        for (int k = 0; k < NUM_ARRAY; k++)
            accept[k] = bus.desc_valid && desc_ready && (bus.desc_array == AW'(k));
    end

    always_comb begin
        param_ready_d = 1'b1;
        for (int k = 0; k < NUM_ARRAY; k++) begin
            state_d[k]  = state_q[k];
            // Set once the slot has spent a full cycle in WAIT, so the array's
            // result register has caught up with its done flag.
            waited_d[k] = (state_q[k] == SLOT_WAIT);
            unique case (state_q[k])
                SLOT_IDLE:  if (accept[k])   state_d[k] = SLOT_START;
                SLOT_START:                  state_d[k] = SLOT_RUN;
                SLOT_RUN:   if (arr_done[k]) state_d[k] = SLOT_WAIT;
                SLOT_WAIT:  if (grant[k])    state_d[k] = SLOT_CLEAR;
                SLOT_CLEAR:                  state_d[k] = SLOT_IDLE;
                default:                     state_d[k] = SLOT_IDLE;
            endcase
            start_d[k] = (state_d[k] == SLOT_START);
            clear_d[k] = (state_d[k] == SLOT_CLEAR);
            busy_d[k]  = (state_d[k] != SLOT_IDLE);
            req[k]     = (state_q[k] == SLOT_WAIT) && waited_q[k];
            if (state_d[k] != SLOT_IDLE) param_ready_d = 1'b0;
        end
    end

    always_comb begin
        tile_id_d   = tile_id_q;
        ref_len_d   = ref_len_q;
        query_len_d = query_len_q;
        align_d     = align_q;
        for (int k = 0; k < NUM_ARRAY; k++) begin
            if (accept[k]) begin
                tile_id_d[k*TILE_ID_W +: TILE_ID_W] = bus.desc_tile_id;
                ref_len_d[k*LW +: LW]               = bus.desc_ref_len;
                query_len_d[k*LW +: LW]             = bus.desc_query_len;
                align_d[k*ALIGN_W +: ALIGN_W]       = bus.desc_align;
            end
        end
    end

    always_comb begin
        in_params_d  = load_ok ? param_in : in_params_q;
        set_param_d  = {NUM_ARRAY{load_ok}};
        params_set_d = params_set_q | load_ok;
    end

    assign can_grant = !res_valid_q || bus.res_ready;

    bsw_rr_arbiter #(.N(NUM_ARRAY)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (can_grant),
        .grant   (grant)
    );

    always_comb begin
        res_valid_d = res_valid_q && !bus.res_ready;
        res_data_d  = res_data_q;
        for (int k = 0; k < NUM_ARRAY; k++) begin
            if (grant[k]) begin
                res_valid_d = 1'b1;
                res_data_d  = arr_tile_output[k*RESULT_W +: RESULT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_ARRAY; k++) state_q[k] <= SLOT_IDLE;
            waited_q      <= '0;
            start_q       <= '0;
            clear_q       <= '0;
            busy_q        <= '0;
            tile_id_q     <= '0;
            ref_len_q     <= '0;
            query_len_q   <= '0;
            align_q       <= '0;
            params_set_q  <= 1'b0;
            param_ready_q <= 1'b0;
            set_param_q   <= '0;
            in_params_q   <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
        end else begin
            for (int k = 0; k < NUM_ARRAY; k++) state_q[k] <= state_d[k];
            waited_q      <= waited_d;
            start_q       <= start_d;
            clear_q       <= clear_d;
            busy_q        <= busy_d;
            tile_id_q     <= tile_id_d;
            ref_len_q     <= ref_len_d;
            query_len_q   <= query_len_d;
            align_q       <= align_d;
            params_set_q  <= params_set_d;
            param_ready_q <= param_ready_d;
            set_param_q   <= set_param_d;
            in_params_q   <= in_params_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
        end
    end

    assign bus.desc_ready  = desc_ready;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign param_ready     = param_ready_q;
    assign arr_set_param   = set_param_q;
    assign arr_in_params   = in_params_q;
    assign arr_start       = start_q;
    assign arr_clear_done  = clear_q;
    assign busy_mask       = busy_q;
    assign arr_tile_id     = tile_id_q;
    assign arr_ref_len     = ref_len_q;
    assign arr_query_len   = query_len_q;
    assign arr_align       = align_q;

endmodule

// File: tb/tb_bsw_tile_dispatcher.sv
// Directed bench for bsw_tile_dispatcher with a small behavioural array model:
// done is held from the bench raising it until the dispatcher's clear_done,
// and each array's result word is updated one cycle after its done rises.
module tb_bsw_tile_dispatcher;
    import bsw_tile_dispatcher_pkg::*;

    localparam int NA = 4;
    localparam int PE = 25;
    localparam int LM = 11;
    localparam int PW = 13 * PE;
    localparam int RW = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              param_load;
    logic [PW-1:0]     param_in;
    logic              param_ready;
    logic [NA-1:0]     arr_set_param, arr_start, arr_ready, arr_done, arr_clear_done, busy_mask;
    logic [PW-1:0]     arr_in_params;
    logic [NA*32-1:0]  arr_tile_id;
    logic [NA*LM-1:0]  arr_ref_len, arr_query_len;
    logic [NA*8-1:0]   arr_align;
    logic [NA*RW-1:0]  arr_tile_output;

    bsw_tile_dispatcher_if #(.NUM_ARRAY(NA), .LOG_MAX_TILE_SIZE(LM)) bus ();

    bsw_tile_dispatcher #(.NUM_ARRAY(NA), .PE_WIDTH(PE), .LOG_MAX_TILE_SIZE(LM)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .param_load      (param_load),
        .param_in        (param_in),
        .param_ready     (param_ready),
        .bus             (bus),
        .arr_set_param   (arr_set_param),
        .arr_in_params   (arr_in_params),
        .arr_start       (arr_start),
        .arr_ready       (arr_ready),
        .arr_done        (arr_done),
        .arr_clear_done  (arr_clear_done),
        .arr_tile_id     (arr_tile_id),
        .arr_ref_len     (arr_ref_len),
        .arr_query_len   (arr_query_len),
        .arr_align       (arr_align),
        .arr_tile_output (arr_tile_output),
        .busy_mask       (busy_mask)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // array model
    int done_cnt [NA] = '{default: 0};
    int clr_cnt  [NA] = '{default: 0};
    for (genvar g = 0; g < NA; g++) begin : g_done
        assign arr_done[g] = (done_cnt[g] != clr_cnt[g]);
    end
    always @(posedge clk)
        for (int k = 0; k < NA; k++)
            if (arr_clear_done[k]) clr_cnt[k] <= clr_cnt[k] + 1;

    // result log
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [RW-1:0] got_q [$];
    int            got_cyc [$];
    always @(negedge clk)
        if (rst_n && bus.res_valid && bus.res_ready) begin
            got_q.push_back(bus.res_data);
            got_cyc.push_back(cyc);
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] mk_word(input int k, input int id, input int rl, input int ql);
        logic [439:0] pad;
        pad = {55{8'(8'hA0 + k)}};
        return {8'(k), 32'(id), 16'(rl), 16'(ql), pad};
    endfunction

    task automatic send_desc(input int k, input int id, input int rl, input int ql, input int al);
        bus.desc_valid     = 1'b1;
        bus.desc_array     = 2'(k);
        bus.desc_tile_id   = 32'(id);
        bus.desc_ref_len   = 11'(rl);
        bus.desc_query_len = 11'(ql);
        bus.desc_align     = 8'(al);
        #1;
        check($sformatf("desc_ready_s%0d", k), bus.desc_ready, 1);
        tick();
        bus.desc_valid = 1'b0;
        check($sformatf("start_s%0d", k), arr_start, 1 << k);
        check($sformatf("busy_s%0d", k), busy_mask[k], 1);
        check($sformatf("tile_id_s%0d", k), arr_tile_id[k*32 +: 32], id);
        check($sformatf("ref_len_s%0d", k), arr_ref_len[k*LM +: LM], rl);
        check($sformatf("query_len_s%0d", k), arr_query_len[k*LM +: LM], ql);
        check($sformatf("align_s%0d", k), arr_align[k*8 +: 8], al);
    endtask

    task automatic wait_valid(input int bound, output int lat);
        lat = 0;
        while (!bus.res_valid && lat < bound) begin
            tick();
            lat++;
        end
        if (!bus.res_valid) check("res_valid_timeout", 0, 1);
    endtask

    task automatic wait_count(input int n, input int bound);
        for (int i = 0; i < bound && got_q.size() < n; i++) tick();
        check("result_count", got_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] pvec;
        logic [RW-1:0] w2, w0, w1b, w3b, w0b, w0c, w1c, w2c, w3d;
        int lat, bad, c0, c1, c2;

        param_load         = 1'b0;
        param_in           = '0;
        arr_ready          = '1;
        arr_tile_output    = {NA*16{32'hDEADBEEF}};
        bus.desc_valid     = 1'b0;
        bus.desc_array     = '0;
        bus.desc_tile_id   = '0;
        bus.desc_ref_len   = '0;
        bus.desc_query_len = '0;
        bus.desc_align     = '0;
        bus.res_ready      = 1'b1;
        for (int i = 0; i < 13; i++) pvec[i*PE +: PE] = PE'(i + 1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", arr_start, 0);
        check("rst_clear", arr_clear_done, 0);
        check("rst_set_param", arr_set_param, 0);
        check("rst_in_params", arr_in_params, 0);
        check("rst_tile_id", arr_tile_id, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_param_ready", param_ready, 0);
        check("rst_desc_ready", bus.desc_ready, 0);
        rst_n = 1'b1;
        tick();
        check("param_ready_idle", param_ready, 1);
        check("desc_ready_no_params", bus.desc_ready, 0);

        // parameter load
        param_in   = pvec;
        param_load = 1'b1;
        tick();
        param_load = 1'b0;
        check("set_param_pulse", arr_set_param, 4'hF);
        check("in_params_w0", arr_in_params[PE-1:0], 1);
        check("in_params_w12", arr_in_params[12*PE +: PE], 13);
        bus.desc_array = 2'd2;
        #1;
        check("desc_ready_after_params", bus.desc_ready, 1);
        tick();
        check("set_param_one_cycle", arr_set_param, 0);

        // single tile on array 2
        send_desc(2, 7, 100, 90, 8'h5A);
        tick();
        check("start_one_cycle", arr_start, 0);
        check("param_ready_busy", param_ready, 0);
        param_in   = '1;
        param_load = 1'b1;
        tick();
        param_load = 1'b0;
        param_in   = pvec;
        check("busy_load_no_set_param", arr_set_param, 0);
        check("busy_load_params_kept", arr_in_params[PE-1:0], 1);
        bus.desc_array = 2'd2;
        #1;
        check("desc_ready_busy_slot", bus.desc_ready, 0);
        bus.desc_array = 2'd1;
        arr_ready[1]   = 1'b0;
        #1;
        check("desc_ready_arr_not_ready", bus.desc_ready, 0);
        arr_ready[1] = 1'b1;
        w2 = mk_word(2, 7, 100, 90);
        done_cnt[2]++;
        tick();
        arr_tile_output[2*RW +: RW] = w2;
        wait_valid(10, lat);
        check("res_latency", lat, 2);
        check("res_data_s2", bus.res_data, w2);
        check("clear_pulse_s2", arr_clear_done, 4'b0100);
        check("held_ref_in_clear", arr_ref_len[2*LM +: LM], 100);
        tick();
        check("res_drained", bus.res_valid, 0);
        check("clear_one_cycle", arr_clear_done, 0);
        check("busy_after_clear", busy_mask, 0);
        check("clear_count_s2", clr_cnt[2], 1);

        // pointer now at 3; one tile on slot 0 moves it to 1
        send_desc(0, 11, 50, 40, 8'h01);
        tick();
        w0 = mk_word(0, 11, 50, 40);
        done_cnt[0]++;
        tick();
        arr_tile_output[0*RW +: RW] = w0;
        wait_valid(10, lat);
        check("res_data_s0", bus.res_data, w0);
        tick();
        tick();

        // simultaneous done on 0,1,3 with pointer at 1 -> order 1,3,0
        send_desc(1, 21, 200, 210, 8'h02);
        send_desc(3, 23, 300, 310, 8'h03);
        send_desc(0, 20, 400, 410, 8'h04);
        tick();
        w1b = mk_word(1, 21, 200, 210);
        w3b = mk_word(3, 23, 300, 310);
        w0b = mk_word(0, 20, 400, 410);
        got_q.delete();
        got_cyc.delete();
        done_cnt[0]++; done_cnt[1]++; done_cnt[3]++;
        tick();
        arr_tile_output[0*RW +: RW] = w0b;
        arr_tile_output[1*RW +: RW] = w1b;
        arr_tile_output[3*RW +: RW] = w3b;
        wait_count(3, 20);
        if (got_q.size() == 3) begin
            check("rr_first_s1", got_q[0], w1b);
            check("rr_second_s3", got_q[1], w3b);
            check("rr_third_s0", got_q[2], w0b);
            check("rr_b2b_1", got_cyc[1] - got_cyc[0], 1);
            check("rr_b2b_2", got_cyc[2] - got_cyc[1], 1);
        end
        tick();
        tick();

        // backpressure: pointer at 1, slots 0,1,2 done -> order 1,2,0
        send_desc(0, 30, 10, 11, 8'h10);
        send_desc(1, 31, 12, 13, 8'h11);
        send_desc(2, 32, 14, 15, 8'h12);
        tick();
        w0c = mk_word(0, 30, 10, 11);
        w1c = mk_word(1, 31, 12, 13);
        w2c = mk_word(2, 32, 14, 15);
        bus.res_ready = 1'b0;
        c0 = clr_cnt[0]; c1 = clr_cnt[1]; c2 = clr_cnt[2];
        done_cnt[0]++; done_cnt[1]++; done_cnt[2]++;
        tick();
        arr_tile_output[0*RW +: RW] = w0c;
        arr_tile_output[1*RW +: RW] = w1c;
        arr_tile_output[2*RW +: RW] = w2c;
        wait_valid(10, lat);
        check("bp_first_data", bus.res_data, w1c);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.res_data !== w1c || bus.res_valid !== 1'b1) bad++;
        end
        check("bp_data_stable", bad, 0);
        check("bp_clear_s1_once", clr_cnt[1] - c1, 1);
        check("bp_no_clear_s0", clr_cnt[0] - c0, 0);
        check("bp_no_clear_s2", clr_cnt[2] - c2, 0);
        check("bp_others_wait", busy_mask, 4'b0101);
        got_q.delete();
        got_cyc.delete();
        bus.res_ready = 1'b1;
        wait_count(3, 20);
        if (got_q.size() == 3) begin
            check("bp_order_s1", got_q[0], w1c);
            check("bp_order_s2", got_q[1], w2c);
            check("bp_order_s0", got_q[2], w0c);
        end
        tick();
        tick();

        // busy-slot refusal and accept concurrent with a grant
        send_desc(1, 41, 33, 34, 8'h21);
        tick();
        bus.desc_array = 2'd1;
        #1;
        check("desc_ready_busy_s1", bus.desc_ready, 0);
        send_desc(3, 43, 35, 36, 8'h23);
        tick();
        w3d = mk_word(3, 43, 35, 36);
        done_cnt[3]++;
        tick();
        arr_tile_output[3*RW +: RW] = w3d;
        tick();
        bus.desc_valid     = 1'b1;
        bus.desc_array     = 2'd0;
        bus.desc_tile_id   = 32'd40;
        bus.desc_ref_len   = 11'd37;
        bus.desc_query_len = 11'd38;
        bus.desc_align     = 8'h20;
        #1;
        check("desc_ready_during_grant", bus.desc_ready, 1);
        tick();
        bus.desc_valid = 1'b0;
        check("concurrent_start_s0", arr_start, 4'b0001);
        check("concurrent_res_valid", bus.res_valid, 1);
        check("concurrent_res_data", bus.res_data, w3d);
        check("concurrent_clear_s3", arr_clear_done, 4'b1000);
        bus.desc_array = 2'd3;
        #1;
        check("desc_ready_in_clear", bus.desc_ready, 0);
        tick();
        check("desc_ready_after_clear", bus.desc_ready, 1);
        tick();

        // reset mid-RUN
        check("pre_reset_busy", busy_mask, 4'b0011);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_mask, 0);
        check("midrst_res_data", bus.res_data, 0);
        check("midrst_tile_id", arr_tile_id, 0);
        check("midrst_in_params", arr_in_params, 0);
        check("midrst_param_ready", param_ready, 0);
        check("midrst_desc_ready", bus.desc_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.desc_array = 2'd2;
        #1;
        check("post_rst_desc_ready", bus.desc_ready, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
